multi_digit_segment_animator: RTL

Parametrised successor to the single-digit animated 7-segment driver: a multiplexed N-digit display that buffers incoming segment patterns in a small FIFO and scrolls each new character in from the right. Each character is revealed segment by segment, one segment per frame tick. The block includes its own frame and scan prescalers and PWM brightness control, and drives common segment lines plus one-hot digit enables directly to the output pins.

---
 rtl/multi_digit_segment_animator.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_digit_segment_animator.sv
// Multiplexed N-digit 7-segment driver. Incoming segment patterns are queued
// in a small FIFO. Each new character scrolls the display left and is then
// revealed in digit 0, one segment (a..g) per frame tick, and held for a
// number of frame ticks before the next character is taken.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   enable            run when high; freezes all state and blanks outputs when low
//   clear             one-cycle flush of FIFO, display and animation
//   char_valid/data   push interface (bit0 = seg a ... bit6 = seg g)
//   char_ready        FIFO not full (combinational), low during reset
//   brightness        PWM duty level; all-ones forces always on
//   seg, digit_en     registered segment lines and one-hot digit select
//   busy              animation in progress or characters pending
module multi_digit_segment_animator #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned FRAME_DIV   = 200000,
   parameter int unsigned SCAN_DIV    = 1000,
   parameter int unsigned HOLD_FRAMES = 8,
   parameter int unsigned PWM_BITS    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic                char_valid,
   input  logic [6:0]          char_data,
   output logic                char_ready,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [6:0]          seg,
   output logic [DIGITS-1:0]   digit_en,
   output logic                busy
);

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PW      = AW + 1;
   localparam int unsigned FRAME_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned STEP_W  = 3;
   localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WIPE = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state, state_d;

   logic [SEG_W-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [PW-1:0]      count;
   logic               empty, full;

   logic [SEG_W-1:0]   disp [DIGITS];
   logic [SEG_W-1:0]   cur;
   logic [STEP_W-1:0]  step, step_d;
   logic [HOLD_W-1:0]  hold, hold_d;

   logic [FRAME_W-1:0] frame_cnt;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]   idx;
   logic [PWM_BITS-1:0] pwm_cnt;

   logic               frame_tick;
   logic               pwm_on;
   logic               push;
   logic               pop;
   logic               wipe_upd;
   logic [7:0]         wipe_mask;
   logic [SEG_W-1:0]   wipe_val;

   // FIFO status; pointers carry one extra bit to tell full from empty
   assign count      = wr_ptr - rd_ptr;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (count == PW'(FIFO_DEPTH));
   assign char_ready = !reset && !full;
   assign push       = char_valid && char_ready && enable;
   assign busy       = (state != IDLE) || !empty;

   assign frame_tick = enable && (frame_cnt == FRAME_W'(FRAME_DIV - 1));
   assign pwm_on     = (pwm_cnt < brightness) || (&brightness);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else if (enable) begin
         state <= clear ? IDLE : state_d;
      end
   end

   // Next-state and animation control
   always_comb begin
      state_d   = state;
      pop       = 1'b0;
      step_d    = step;
      hold_d    = hold;
      wipe_upd  = 1'b0;
      wipe_mask = 8'd0;
      wipe_val  = '0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               step_d  = '0;
               state_d = WIPE;
            end
         end
         WIPE: begin
            if (frame_tick) begin
               step_d   = step + STEP_W'(1);
               wipe_upd = 1'b1;
               if (step_d == STEP_W'(SEG_W)) begin
                  hold_d  = '0;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (frame_tick) begin
               hold_d = hold + HOLD_W'(1);
               if (hold_d == HOLD_W'(HOLD_FRAMES)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Low `step_d` segments of the current character are visible
      wipe_mask = (8'd1 << step_d) - 8'd1;
      wipe_val  = cur & wipe_mask[SEG_W-1:0];
   end

   // FIFO, display memory and animation counters
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cur    <= '0;
         step   <= '0;
         hold   <= '0;
         for (int i = 0; i < int'(DIGITS); i++) disp[i] <= '0;
      end else if (enable) begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cur    <= '0;
            for (int i = 0; i < int'(DIGITS); i++) disp[i] <= '0;
         end else begin
            step <= step_d;
            hold <= hold_d;
            if (push) begin
               mem[wr_ptr[AW-1:0]] <= char_data;
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               cur    <= mem[rd_ptr[AW-1:0]];
               rd_ptr <= rd_ptr + PW'(1);
               for (int i = int'(DIGITS) - 1; i > 0; i--) disp[i] <= disp[i-1];
               disp[0] <= '0;
            end else if (wipe_upd) begin
               disp[0] <= wipe_val;
            end
         end
      end
   end

   // Frame, scan and PWM prescalers
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         scan_cnt  <= '0;
         idx       <= '0;
         pwm_cnt   <= '0;
      end else if (enable) begin
         frame_cnt <= frame_tick ? '0 : frame_cnt + FRAME_W'(1);
         pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
         if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
      end
   end

   // Pin drivers, one clock behind idx/disp/pwm_on
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         seg      <= '0;
         digit_en <= '0;
      end else begin
         seg      <= disp[idx] & {SEG_W{pwm_on}};
         digit_en <= DIGITS'(1) << idx;
      end
   end

endmodule
